// File: rtl/uart_pkg.sv
// Shared UART constants: frame shape, default divisor and FSM state encoding.
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud
    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned STOP_BITS            = 1;

    // Receiver state encoding, kept as plain constants for older tool flows
    typedef logic [1:0] uart_state_t;
    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset value selectable.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops to settle metastability before use
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, byte strobe on good frames, ferr on bad stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 ready,
    output logic                 ferr,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 brk_q, brk_d;    // stop bit was low; waiting for line to go idle
    logic                 ready_q, ready_d;
    logic                 ferr_q, ferr_d;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Next-state logic for the frame FSM, bit timer, bit index and shift register
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        brk_d   = brk_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    timer_d = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (timer_q == HALF_END) begin
                    timer_d = '0;
                    idx_d   = '0;
                    // High at mid start bit means the falling edge was a glitch
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (timer_q == BIT_END) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (brk_q) begin
                    // Hold through a break until the line returns high
                    if (rx_s) begin
                        brk_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (timer_q == BIT_END) begin
                    timer_d = '0;
                    if (rx_s) begin
                        dout_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d = 1'b1;
                        brk_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset discards any partial frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            brk_q   <= 1'b0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            brk_q   <= brk_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dout  = dout_q;
    assign ready = ready_q;
    assign ferr  = ferr_q;
    assign busy  = (state_q != ST_IDLE);

endmodule
